example_sweep_ctrl: RTL and testbench

Sequencer for the 6-input combinational `example` logic block. On `start` it drives all 64 input vectors in ascending order and waits a programmable settle time per vector. It then samples the block's output into a 64-bit truth-table register and compares each sample against a latched expected table. It reports pass/fail, mismatch count and first failing vector, and sits beside the `example` instance as its self-check / characterisation controller.

---
 rtl/example_sweep_ctrl_pkg.sv | 16 +
 rtl/sweep_settle_cnt.sv | 29 ++
 rtl/example_sweep_ctrl.sv | 116 +++++++++++
 tb/tb_example_sweep_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/example_sweep_ctrl_pkg.sv
// rtl/example_sweep_ctrl_pkg.sv - shared types and constants for the example sweep controller
package example_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } sweep_state_t;

  localparam int N_IN = 6;
  localparam int NVEC = 64;
  localparam logic [N_IN-1:0] LAST_VEC = 6'd63;

endpackage

// File: rtl/sweep_settle_cnt.sv
// rtl/sweep_settle_cnt.sv - 4-bit settle counter with clear/enable and terminal flag
module sweep_settle_cnt #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  // last flags the final settle cycle so the FSM leaves SETTLE on that edge
  localparam logic [3:0] LAST_CNT = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/example_sweep_ctrl.sv
// rtl/example_sweep_ctrl.sv - drives all 64 input vectors into `example` and checks Y against a golden table
module example_sweep_ctrl
  import example_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [NVEC-1:0] expected,
  input  logic            y_in,
  output logic [N_IN-1:0] drv,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [6:0]      err_cnt,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_vld,
  output logic [NVEC-1:0] truth
);

  localparam bit SKIP_SETTLE = (SETTLE_CYC == 0);

  sweep_state_t    state;
  logic [N_IN-1:0] vec;
  logic [NVEC-1:0] exp_l;
  logic            settle_last;
  logic            go;

  sweep_settle_cnt #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == S_LOAD),
    .en    (state == S_SETTLE),
    .last  (settle_last)
  );

  // A new sweep may only begin from rest; start while mid-sweep is dropped
  assign go = start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      vec            <= '0;
      exp_l          <= '0;
      drv            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
      truth          <= '0;
    end else if (abort && (state != S_IDLE)) begin
      // partial truth/err_cnt/first_fail are kept for post-mortem inspection
      state <= S_IDLE;
      drv   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          drv  <= '0;
          busy <= 1'b0;
        end
        S_LOAD: begin
          drv   <= vec;
          busy  <= 1'b1;
          state <= SKIP_SETTLE ? S_SAMPLE : S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_last) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          truth[vec] <= y_in;
          if (y_in != exp_l[vec]) begin
            err_cnt <= err_cnt + 7'd1;
            if (!first_fail_vld) begin
              first_fail     <= vec;
              first_fail_vld <= 1'b1;
            end
          end
          if (vec == LAST_VEC) begin
            state <= S_DONE;
          end else begin
            vec   <= vec + 6'd1;
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (err_cnt == 7'd0);
        end
        default: state <= S_IDLE;
      endcase

      if (go) begin
        state          <= S_LOAD;
        vec            <= '0;
        exp_l          <= expected;
        truth          <= '0;
        err_cnt        <= '0;
        first_fail     <= '0;
        first_fail_vld <= 1'b0;
        done           <= 1'b0;
        pass           <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_example_sweep_ctrl.sv
// tb/tb_example_sweep_ctrl.sv - self-checking bench for example_sweep_ctrl
module tb_example_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic [63:0] expected, func;

  logic [5:0]  drv [3];
  logic        busy [3], done [3], pass [3], ffv [3], y_in [3];
  logic [6:0]  err_cnt [3];
  logic [5:0]  ff [3];
  logic [63:0] truth [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic int sc(input int g);
    return (g == 0) ? 2 : (g == 1) ? 0 : 15;
  endfunction

  // Instance 0 runs the default settle time; 1 and 2 cover the range ends
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign y_in[g] = func[drv[g]];
    example_sweep_ctrl #(.SETTLE_CYC((g == 0) ? 2 : (g == 1) ? 0 : 15)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .abort          (abort),
      .expected       (expected),
      .y_in           (y_in[g]),
      .drv            (drv[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .pass           (pass[g]),
      .err_cnt        (err_cnt[g]),
      .first_fail     (ff[g]),
      .first_fail_vld (ffv[g]),
      .truth          (truth[g])
    );
  end

  typedef struct {
    logic [63:0] f;
    logic [63:0] e;
    bit          perturb;
    int          x_err;
    int          x_ff;
    bit          x_ffv;
    bit          x_pass;
  } vec_t;

  vec_t tbl [8];

  function automatic int popc(input logic [63:0] x);
    int c = 0;
    for (int i = 0; i < 64; i++) c += int'(x[i]);
    return c;
  endfunction

  function automatic int lowest(input logic [63:0] x);
    for (int i = 0; i < 64; i++) if (x[i]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"}, {drv[0], busy[0], done[0], pass[0], err_cnt[0], ff[0], ffv[0]}, 64'd0);
    chk({nm, "_truth"}, truth[0], 64'd0);
  endtask

  task automatic run_sweep(input vec_t t, input string nm);
    int dedge [3];
    int busy_cnt = 0;
    int drv_bad = 0;
    func = t.f;
    expected = t.e;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int g = 0; g < 3; g++) dedge[g] = 0;
    for (int ed = 1; ed <= 1200; ed++) begin
      if (t.perturb && ed == 5) expected = {$urandom(), $urandom()};
      tick();
      if (busy[0]) busy_cnt++;
      if ((ed - 1) % 4 == 0 && ed <= 253 && drv[0] != 6'((ed - 1) / 4)) drv_bad++;
      for (int g = 0; g < 3; g++) if (done[g] && dedge[g] == 0) dedge[g] = ed;
      if (dedge[0] != 0 && dedge[1] != 0 && dedge[2] != 0) break;
    end
    for (int g = 0; g < 3; g++)
      chk($sformatf("%s_done_edge_s%0d", nm, sc(g)), 64'(dedge[g]), 64'(64 * (sc(g) + 2) + 1));
    chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'd256);
    chk({nm, "_drv_seq_bad"}, 64'(drv_bad), 64'd0);
    chk({nm, "_err_cnt"}, 64'(err_cnt[0]), 64'(t.x_err));
    chk({nm, "_ffv"}, 64'(ffv[0]), 64'(t.x_ffv));
    if (t.x_ffv) chk({nm, "_first_fail"}, 64'(ff[0]), 64'(t.x_ff));
    chk({nm, "_pass"}, 64'(pass[0]), 64'(t.x_pass));
    chk({nm, "_truth"}, truth[0], t.f);
    chk({nm, "_drv_hold"}, 64'(drv[0]), 64'd63);
    chk({nm, "_err_cnt_s15"}, 64'(err_cnt[2]), 64'(t.x_err));
    chk({nm, "_pass_s0"}, 64'(pass[1]), 64'(t.x_pass));
  endtask

  initial begin
    logic [63:0] ad, m;
    for (int v = 0; v < 64; v++) ad[v] = v[5] & v[2];
    tbl[0] = '{ad, ad, 1'b0, 0, 0, 1'b0, 1'b1};
    tbl[1] = '{ad, ad ^ (64'd1 << 5) ^ (64'd1 << 40), 1'b0, 2, 5, 1'b1, 1'b0};
    tbl[2] = '{ad, ~ad, 1'b0, 64, 0, 1'b1, 1'b0};
    tbl[3] = '{ad, ad, 1'b1, 0, 0, 1'b0, 1'b1};
    for (int i = 4; i < 8; i++) begin
      func = {$urandom(), $urandom()};
      if (i == 4) m = 64'd0;
      else if (i == 5) m = {$urandom(), $urandom()};
      else m = (64'd1 << $urandom_range(63, 0)) | (64'd1 << $urandom_range(63, 0));
      tbl[i] = '{func, func ^ m, 1'b1, popc(m), lowest(m), m != 0, m == 0};
    end

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = '0; func = '0;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 64'(busy[0]), 64'd0);

    for (int i = 0; i < 4; i++) run_sweep(tbl[i], $sformatf("tbl%0d", i));

    // abort at edge 40 with a start at edge 30 that must be ignored
    func = ~ad;
    expected = func ^ (64'd1 << 3) ^ (64'd1 << 20);
    start = 1'b1;
    tick();
    for (int e = 1; e <= 40; e++) begin
      start = (e == 30);
      abort = (e == 40);
      tick();
      if (e == 31) chk("abort_start_ignored_drv", 64'(drv[0]), 64'd7);
    end
    start = 1'b0;
    abort = 1'b0;
    chk("abort_ctl", {drv[0], busy[0], done[0], pass[0]}, 64'd0);
    chk("abort_err_cnt", 64'(err_cnt[0]), 64'd1);
    chk("abort_first_fail", {ffv[0], ff[0]}, {57'd0, 1'b1, 6'd3});
    chk("abort_truth", truth[0], func & 64'h1FF);
    tick();
    tick();
    chk("abort_idle", {drv[0], busy[0]}, 64'd0);

    // reset at edge 100 mid-sweep, start held during reset must not launch
    func = '1;
    expected = '0;
    start = 1'b1;
    tick();
    for (int e = 1; e <= 100; e++) begin
      rst_n = (e != 100);
      start = (e == 100);
      tick();
    end
    chk_zero("midreset");
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    chk("midreset_idle", {drv[0], busy[0], done[0]}, 64'd0);

    for (int i = 4; i < 8; i++) run_sweep(tbl[i], $sformatf("tbl%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
